// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-RAM arbiter between instruction fetch and load/store.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        LS_ACC = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_IF   = 2'd1,
        WIN_LS   = 2'd2
    } winner_e;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    localparam logic [2:0] ST_SB  = 3'b000;
    localparam logic [2:0] ST_SH  = 3'b001;
    localparam logic [2:0] ST_SW  = 3'b010;

    // Width of the IF starvation counter; bounds the usable starvation limit to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [2:0]        ls_load_type;
    logic [2:0]        ls_store_type;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              stall_if;
    logic              stall_ls;

    logic              mem_read_en;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_load_type;
    logic [2:0]        mem_store_type;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_load_type, ls_store_type,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output stall_if, stall_ls,
        output mem_read_en, mem_write_en, mem_addr, mem_wdata, mem_load_type, mem_store_type
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_load_type, ls_store_type,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  stall_if, stall_ls,
        input  mem_read_en, mem_write_en, mem_addr, mem_wdata, mem_load_type, mem_store_type
    );

endinterface

// File: rtl/mem_arb_prio.sv
// Combinational winner select: LSU beats IF unless IF has been starved to the limit.
module mem_arb_prio
    import mem_arb_pkg::*;
(
    input  logic    if_req_i,
    input  logic    ls_req_i,
    input  logic    starve_i,
    output winner_e winner_o
);

    // Priority resolution for the current arbitration cycle.
    always_comb begin
        winner_o = WIN_NONE;
        if (if_req_i && starve_i) begin
            winner_o = WIN_IF;
        end else if (ls_req_i) begin
            winner_o = WIN_LS;
        end else if (if_req_i) begin
            winner_o = WIN_IF;
        end else begin
            winner_o = WIN_NONE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: one access per two cycles, grant and memory drive in the same cycle.
// Optional MEM_ARB_PERF_EN adds grant/conflict performance counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_ls_grants,
    output logic [31:0] perf_conflicts,
`endif
    mem_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e        state_q;
    logic [CNT_W-1:0]  starve_q;
    logic              ls_we_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;

    winner_e winner_s;
    logic    idle_s;
    logic    starve_s;
    logic    if_gnt_s;
    logic    ls_gnt_s;
    logic    if_rvalid_s;
    logic    ls_rvalid_s;

    // Gating with reset_n keeps every output quiet while reset is held.
    assign idle_s      = reset_n && (state_q == IDLE);
    assign starve_s    = (starve_q == STARVE_LIM);
    assign if_rvalid_s = reset_n && (state_q == IF_ACC);
    assign ls_rvalid_s = reset_n && (state_q == LS_ACC);

    mem_arb_prio u_prio (
        .if_req_i (bus.if_req && idle_s),
        .ls_req_i (bus.ls_req && idle_s),
        .starve_i (starve_s),
        .winner_o (winner_s)
    );

    assign if_gnt_s = (winner_s == WIN_IF);
    assign ls_gnt_s = (winner_s == WIN_LS);

    assign bus.if_gnt    = if_gnt_s;
    assign bus.ls_gnt    = ls_gnt_s;
    assign bus.if_rvalid = if_rvalid_s;
    assign bus.ls_rvalid = ls_rvalid_s;
    assign bus.if_rdata  = if_rvalid_s ? bus.mem_rdata : if_rdata_q;
    assign bus.ls_rdata  = (ls_rvalid_s && !ls_we_q) ? bus.mem_rdata : ls_rdata_q;
    assign bus.stall_if  = reset_n && bus.if_req && !if_gnt_s;
    assign bus.stall_ls  = reset_n && bus.ls_req && (state_q != LS_ACC);

    // Memory port carries the winner's request only in its grant cycle.
    always_comb begin
        bus.mem_read_en    = 1'b0;
        bus.mem_write_en   = 1'b0;
        bus.mem_addr       = {ADDR_W{1'b0}};
        bus.mem_wdata      = {DATA_W{1'b0}};
        bus.mem_load_type  = 3'b000;
        bus.mem_store_type = 3'b000;
        case (winner_s)
            WIN_IF: begin
                bus.mem_read_en   = 1'b1;
                bus.mem_addr      = bus.if_addr;
                bus.mem_load_type = LT_LW;
            end
            WIN_LS: begin
                bus.mem_read_en    = !bus.ls_we;
                bus.mem_write_en   = bus.ls_we;
                bus.mem_addr       = bus.ls_addr;
                bus.mem_wdata      = bus.ls_wdata;
                bus.mem_load_type  = bus.ls_load_type;
                bus.mem_store_type = bus.ls_store_type;
            end
            default: begin
                bus.mem_read_en = 1'b0;
            end
        endcase
    end

    // Access FSM, read-data capture and IF starvation tracking.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            starve_q   <= {CNT_W{1'b0}};
            ls_we_q    <= 1'b0;
            if_rdata_q <= {DATA_W{1'b0}};
            ls_rdata_q <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_gnt_s) begin
                        state_q <= IF_ACC;
                    end else if (ls_gnt_s) begin
                        state_q <= LS_ACC;
                        ls_we_q <= bus.ls_we;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                IF_ACC: begin
                    if_rdata_q <= bus.mem_rdata;
                    state_q    <= IDLE;
                end
                LS_ACC: begin
                    if (!ls_we_q) begin
                        ls_rdata_q <= bus.mem_rdata;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (if_gnt_s) begin
                starve_q <= {CNT_W{1'b0}};
            end else if (bus.if_req && ls_gnt_s) begin
                if (starve_q < STARVE_LIM) begin
                    starve_q <= starve_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else if ((state_q == IDLE) && !bus.if_req) begin
                starve_q <= {CNT_W{1'b0}};
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q;
    logic [31:0] perf_ls_q;
    logic [31:0] perf_cf_q;

    // Free-running, wrapping event counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_if_q <= 32'd0;
            perf_ls_q <= 32'd0;
            perf_cf_q <= 32'd0;
        end else begin
            if (if_gnt_s) begin
                perf_if_q <= perf_if_q + 32'd1;
            end
            if (ls_gnt_s) begin
                perf_ls_q <= perf_ls_q + 32'd1;
            end
            if (idle_s && bus.if_req && bus.ls_req) begin
                perf_cf_q <= perf_cf_q + 32'd1;
            end
        end
    end

    assign perf_if_grants = perf_if_q;
    assign perf_ls_grants = perf_ls_q;
    assign perf_conflicts = perf_cf_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants/responses, a negedge monitor checks them.
module tb_mem_arbiter;

    typedef struct packed {
        logic        if_g;
        logic        ls_g;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  lt;
        logic [2:0]  st;
    } gnt_t;

    typedef struct packed {
        logic        if_v;
        logic        ls_v;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic [31:0] mem_rdata_r = 32'h0;
    int n_cmp = 0;
    int n_err = 0;
    gnt_t gnt_q[$];
    rsp_t rsp_q[$];

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if;
    logic [31:0] perf_ls;
    logic [31:0] perf_cf;
`endif

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
`ifdef MEM_ARB_PERF_EN
        .perf_if_grants (perf_if),
        .perf_ls_grants (perf_ls),
        .perf_conflicts (perf_cf),
`endif
        .bus            (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h0000_0013;
            32'h0000_0044: return 32'h0010_0093;
            32'h0000_0100: return 32'hDEAD_BEEF;
            default:       return 32'hC0DE_0000 | {16'h0000, a[15:0]};
        endcase
    endfunction

    // Synchronous RAM: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (bus.mem_read_en) mem_rdata_r <= mem_model(bus.mem_addr);
    end
    assign bus.mem_rdata = mem_rdata_r;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req = 1'b0;        bus.if_addr = 32'h0;
        bus.ls_req = 1'b0;        bus.ls_we = 1'b0;
        bus.ls_addr = 32'h0;      bus.ls_wdata = 32'h0;
        bus.ls_load_type = 3'b000; bus.ls_store_type = 3'b000;
    endtask

    task automatic ls_drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] lt, input logic [2:0] st);
        bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_addr = a; bus.ls_wdata = wd;
        bus.ls_load_type = lt; bus.ls_store_type = st;
    endtask

    task automatic exp_if(input logic [31:0] a, input logic [31:0] d);
        gnt_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, a, 32'h0, 3'b010, 3'b000});
        rsp_q.push_back('{1'b1, 1'b0, d});
    endtask

    task automatic exp_ls(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] lt, input logic [2:0] st, input logic [31:0] d);
        gnt_q.push_back('{1'b0, 1'b1, !we, we, a, wd, lt, st});
        rsp_q.push_back('{1'b0, 1'b1, d});
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"},
              128'({bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.stall_if, bus.stall_ls,
                    bus.mem_read_en, bus.mem_write_en, bus.mem_load_type, bus.mem_store_type,
                    bus.if_rdata, bus.ls_rdata}), 128'h0);
        check({name, "_mem"}, 128'({bus.mem_addr, bus.mem_wdata}), 128'h0);
    endtask

    // Monitor: every grant and every response is matched against the scoreboard in order.
    always @(negedge clk) begin : monitor
        gnt_t g;
        rsp_t r;
        if (bus.if_gnt || bus.ls_gnt) begin
            g = '{bus.if_gnt, bus.ls_gnt, bus.mem_read_en, bus.mem_write_en, bus.mem_addr,
                  bus.mem_wdata, bus.mem_load_type, bus.mem_store_type};
            if (gnt_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_gnt: got %h expected none", g);
            end else begin
                check("gnt", 128'(g), 128'(gnt_q.pop_front()));
            end
        end
        if (bus.if_rvalid || bus.ls_rvalid) begin
            r = '{bus.if_rvalid, bus.ls_rvalid, bus.if_rvalid ? bus.if_rdata : bus.ls_rdata};
            check("acc_mem_quiet", 128'({bus.mem_read_en, bus.mem_write_en, bus.if_gnt, bus.ls_gnt}), 128'h0);
            if (rsp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_rvalid: got %h expected none", r);
            end else begin
                check("rsp", 128'(r), 128'(rsp_q.pop_front()));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        reset_n = 1'b1;

        // Lone IF read
        exp_if(32'h40, 32'h0000_0013);
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        @(negedge clk);
        check("s1_stall_if", 128'(bus.stall_if), 128'h0);
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        check("s1_if_rdata_held", 128'(bus.if_rdata), 128'h13);
        tick();

        // Conflict: LSU first, IF in the following IDLE cycle
        exp_ls(1'b0, 32'h100, 32'h0, 3'b010, 3'b000, 32'hDEAD_BEEF);
        exp_if(32'h44, 32'h0010_0093);
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        ls_drive(1'b0, 32'h100, 32'h0, 3'b010, 3'b000);
        @(negedge clk);
        check("s2_stalls_gnt", 128'({bus.stall_if, bus.stall_ls}), 128'h3);
        tick();
        bus.ls_req = 1'b0;
        @(negedge clk);
        check("s2_stall_if_acc", 128'(bus.stall_if), 128'h1);
        tick();
        @(negedge clk);
        check("s2_stall_if_gnt", 128'(bus.stall_if), 128'h0);
        tick();
        idle_inputs();
        tick();
`ifdef MEM_ARB_PERF_EN
        @(negedge clk);
        check("s2_perf_conflicts", 128'(perf_cf), 128'h1);
`endif

        // Store: load data register must be left alone
        exp_ls(1'b1, 32'h203, 32'hAB, 3'b000, 3'b000, 32'hDEAD_BEEF);
        ls_drive(1'b1, 32'h203, 32'hAB, 3'b000, 3'b000);
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        check("s3_ls_rdata_held", 128'(bus.ls_rdata), 128'hDEAD_BEEF);
        tick();

        // Starvation: 4 LSU wins, then IF; counter clears so the pattern repeats
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) exp_ls(1'b0, 32'h300, 32'h0, 3'b010, 3'b000, 32'hC0DE_0300);
            exp_if(32'h48, 32'hC0DE_0048);
        end
        bus.if_req = 1'b1; bus.if_addr = 32'h48;
        ls_drive(1'b0, 32'h300, 32'h0, 3'b010, 3'b000);
        repeat (19) tick();
        idle_inputs();
        tick();
`ifdef MEM_ARB_PERF_EN
        @(negedge clk);
        check("s4_perf_if", 128'(perf_if), 128'd4);
        check("s4_perf_ls", 128'(perf_ls), 128'd10);
        check("s4_perf_cf", 128'(perf_cf), 128'd11);
`endif
        tick();

        // Back-to-back LSU loads
        for (int j = 0; j < 3; j++) exp_ls(1'b0, 32'h100, 32'h0, 3'b010, 3'b000, 32'hDEAD_BEEF);
        ls_drive(1'b0, 32'h100, 32'h0, 3'b010, 3'b000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("s5_stall_ls", 128'(bus.stall_ls), (i % 2 == 0) ? 128'h1 : 128'h0);
            tick();
            if (i == 4) idle_inputs();
        end

        // Reset during LS_ACC drops the response
        gnt_q.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 3'b000});
        ls_drive(1'b0, 32'h100, 32'h0, 3'b010, 3'b000);
        tick();
        reset_n = 1'b0;
        @(negedge clk);
        check("s6_rvalid_dropped", 128'(bus.ls_rvalid), 128'h0);
        tick();
        @(negedge clk);
        check_all_zero("s6_reset");
`ifdef MEM_ARB_PERF_EN
        check("s6_perf_clear", 128'({perf_if, perf_ls, perf_cf}), 128'h0);
`endif
        exp_ls(1'b0, 32'h100, 32'h0, 3'b010, 3'b000, 32'hDEAD_BEEF);
        tick();
        reset_n = 1'b1;
        tick();
        idle_inputs();
        repeat (2) tick();

        check("gnt_queue_drained", 128'(gnt_q.size()), 128'h0);
        check("rsp_queue_drained", 128'(rsp_q.size()), 128'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
